sdram_arbit: RTL and testbench

//  Command arbiter and SDRAM pin driver. Grants the command bus to init, auto-refresh,

---
 rtl/sdram_arbit_if.sv | 55 +++++
 rtl/sdram_arbit.sv | 96 +++++++++
 tb/tb_sdram_arbit.sv | 356 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_arbit_if.sv
// Engine <-> arbiter handshake bundle plus the SDRAM pin/debug outputs.
// master: engine/host side; slave: the arbiter.
interface sdram_arbit_if #(
  parameter int CMD_W = 18
);
  logic [CMD_W-1:0] init_cmd;
  logic [CMD_W-1:0] ref_cmd;
  logic [CMD_W-1:0] wr_cmd;
  logic [CMD_W-1:0] rd_cmd;
  logic init_end;
  logic ref_req;
  logic ref_end;
  logic ref_en;
  logic wr_req;
  logic wr_end;
  logic wr_en;
  logic rd_req;
  logic rd_end;
  logic rd_en;
  logic sdram_cke;
  logic sdram_cs_n;
  logic sdram_ras_n;
  logic sdram_cas_n;
  logic sdram_we_n;
  logic [1:0] sdram_ba;
  logic [11:0] sdram_addr;
  logic [2:0] arb_state;
  logic err_timeout;

  modport master (
    output init_cmd, init_end,
    output ref_req, ref_cmd, ref_end,
    output wr_req, wr_cmd, wr_end,
    output rd_req, rd_cmd, rd_end,
    input  ref_en, wr_en, rd_en,
    input  sdram_cke, sdram_cs_n,
    input  sdram_ras_n, sdram_cas_n,
    input  sdram_we_n, sdram_ba,
    input  sdram_addr, arb_state,
    input  err_timeout
  );

  modport slave (
    input  init_cmd, init_end,
    input  ref_req, ref_cmd, ref_end,
    input  wr_req, wr_cmd, wr_end,
    input  rd_req, rd_cmd, rd_end,
    output ref_en, wr_en, rd_en,
    output sdram_cke, sdram_cs_n,
    output sdram_ras_n, sdram_cas_n,
    output sdram_we_n, sdram_ba,
    output sdram_addr, arb_state,
    output err_timeout
  );
endinterface

// File: rtl/sdram_arbit.sv
// SDRAM command arbiter: grants init/refresh/write/read engines
// the command bus and drives the registered SDRAM pins.
module sdram_arbit #(
  parameter int               CMD_W   = 18,
  parameter logic [CMD_W-1:0] NOP_CMD = 18'h1c000,
  parameter int               TIMEOUT = 1023
) (
  input  logic          clk,
  input  logic          rst,
  sdram_arbit_if.slave  bus
);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_INIT  = 3'd0,
    S_ARBIT = 3'd1,
    S_AREF  = 3'd2,
    S_WRITE = 3'd3,
    S_READ  = 3'd4
  } state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [CMD_W-1:0] pins_q;
  logic [CMD_W-1:0] pins_d;
  logic             err_q;
  logic             owner_end;

  always_comb begin
    pins_d    = NOP_CMD;
    owner_end = 1'b0;
    unique case (state_q)
      S_INIT:  pins_d = bus.init_cmd;
      S_AREF: begin
        pins_d    = bus.ref_cmd;
        owner_end = bus.ref_end;
      end
      S_WRITE: begin
        pins_d    = bus.wr_cmd;
        owner_end = bus.wr_end;
      end
      S_READ: begin
        pins_d    = bus.rd_cmd;
        owner_end = bus.rd_end;
      end
      default: pins_d = NOP_CMD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
      pins_q  <= NOP_CMD;
      err_q   <= 1'b0;
    end else begin
      pins_q <= pins_d;
      unique case (state_q)
        S_INIT: begin
          if (bus.init_end) state_q <= S_ARBIT;
        end
        // ARBIT always precedes a grant, so the counter starts at 0
        S_ARBIT: begin
          cnt_q <= '0;
          if (bus.ref_req)     state_q <= S_AREF;
          else if (bus.wr_req) state_q <= S_WRITE;
          else if (bus.rd_req) state_q <= S_READ;
        end
        S_AREF, S_WRITE, S_READ: begin
          if (owner_end) begin
            state_q <= S_ARBIT;
          end else if (cnt_q == CW'(TIMEOUT - 1)) begin
            state_q <= S_ARBIT;
            err_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= S_INIT;
      endcase
    end
  end

  assign bus.ref_en      = (state_q == S_AREF);
  assign bus.wr_en       = (state_q == S_WRITE);
  assign bus.rd_en       = (state_q == S_READ);
  assign bus.arb_state   = state_q;
  assign bus.err_timeout = err_q;
  assign bus.sdram_cke   = 1'b1;
  assign bus.sdram_cs_n  = pins_q[17];
  assign bus.sdram_ras_n = pins_q[16];
  assign bus.sdram_cas_n = pins_q[15];
  assign bus.sdram_we_n  = pins_q[14];
  assign bus.sdram_ba    = pins_q[13:12];
  assign bus.sdram_addr  = pins_q[11:0];
endmodule

// File: tb/tb_sdram_arbit.sv
// Bench for sdram_arbit: directed scenarios plus random stimulus
// against a cycle-level ownership model.
module tb_sdram_arbit;
  localparam int TO = 15;
  localparam logic [17:0] NOP = 18'h1c000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  // model: owner 0=INIT 1=ARBIT 2=AREF 3=WRITE 4=READ
  int          m_st   = 0;
  int          m_held = 0;
  logic [17:0] m_pins = NOP;
  bit          m_err  = 1'b0;

  sdram_arbit_if ifc ();

  sdram_arbit #(.TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  always #5 clk = ~clk;

  function automatic logic [17:0] pins_obs();
    return {ifc.sdram_cs_n, ifc.sdram_ras_n,
            ifc.sdram_cas_n, ifc.sdram_we_n,
            ifc.sdram_ba, ifc.sdram_addr};
  endfunction

  task automatic model_edge();
    bit done;
    if (rst) begin
      m_st = 0; m_held = 0;
      m_pins = NOP; m_err = 1'b0;
      return;
    end
    case (m_st)
      0: m_pins = ifc.init_cmd;
      2: m_pins = ifc.ref_cmd;
      3: m_pins = ifc.wr_cmd;
      4: m_pins = ifc.rd_cmd;
      default: m_pins = NOP;
    endcase
    case (m_st)
      0: if (ifc.init_end) m_st = 1;
      1: begin
        m_held = 0;
        if (ifc.ref_req)     m_st = 2;
        else if (ifc.wr_req) m_st = 3;
        else if (ifc.rd_req) m_st = 4;
      end
      default: begin
        done = (m_st == 2 && ifc.ref_end) ||
               (m_st == 3 && ifc.wr_end) ||
               (m_st == 4 && ifc.rd_end);
        m_held++;
        if (done) m_st = 1;
        else if (m_held >= TO) begin
          m_st = 1; m_err = 1'b1;
        end
      end
    endcase
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_idle();
    ifc.init_cmd = NOP; ifc.init_end = 1'b0;
    ifc.ref_cmd = NOP;  ifc.ref_req = 1'b0;
    ifc.ref_end = 1'b0;
    ifc.wr_cmd = NOP;   ifc.wr_req = 1'b0;
    ifc.wr_end = 1'b0;
    ifc.rd_cmd = NOP;   ifc.rd_req = 1'b0;
    ifc.rd_end = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_idle();
    repeat (3) step();
    n_tests++;
    if (ifc.arb_state !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_state got %0d want 0", ifc.arb_state);
    end
    n_tests++;
    if ({ifc.ref_en, ifc.wr_en, ifc.rd_en} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_grants got %b want 000",
               {ifc.ref_en, ifc.wr_en, ifc.rd_en});
    end
    n_tests++;
    if (pins_obs() !== NOP) begin
      n_fail++;
      $display("FAIL reset_pins got %h want %h", pins_obs(), NOP);
    end
    n_tests++;
    if (ifc.sdram_cke !== 1'b1 || ifc.err_timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_cke_err got %b%b want 10",
               ifc.sdram_cke, ifc.err_timeout);
    end
    rst = 1'b0;
  endtask

  task automatic test_init();
    ifc.ref_req = 1'b1;
    ifc.wr_req  = 1'b1;
    repeat (4) begin
      step();
      n_tests++;
      if (ifc.arb_state !== 3'd0 || pins_obs() !== NOP) begin
        n_fail++;
        $display("FAIL init_hold got st=%0d pins=%h want 0/%h",
                 ifc.arb_state, pins_obs(), NOP);
      end
    end
    set_idle();
    ifc.init_end = 1'b1;
    step();
    ifc.init_end = 1'b0;
    n_tests++;
    if (ifc.arb_state !== 3'd1 || pins_obs() !== NOP) begin
      n_fail++;
      $display("FAIL init_exit got st=%0d pins=%h want 1/%h",
               ifc.arb_state, pins_obs(), NOP);
    end
    step();
    n_tests++;
    if (ifc.arb_state !== 3'd1) begin
      n_fail++;
      $display("FAIL arbit_idle got %0d want 1", ifc.arb_state);
    end
  endtask

  task automatic test_ref();
    ifc.ref_cmd = 18'h04000;
    ifc.ref_req = 1'b1;
    step();
    n_tests++;
    if (ifc.ref_en !== 1'b1 || ifc.arb_state !== 3'd2) begin
      n_fail++;
      $display("FAIL ref_grant got en=%b st=%0d want 1/2",
               ifc.ref_en, ifc.arb_state);
    end
    ifc.ref_req = 1'b0;
    step();
    n_tests++;
    if (pins_obs() !== 18'h04000) begin
      n_fail++;
      $display("FAIL ref_pins got %h want 04000", pins_obs());
    end
    ifc.ref_end = 1'b1;
    step();
    ifc.ref_end = 1'b0;
    ifc.ref_cmd = NOP;
    n_tests++;
    if (ifc.ref_en !== 1'b0 || ifc.arb_state !== 3'd1) begin
      n_fail++;
      $display("FAIL ref_release got en=%b st=%0d want 0/1",
               ifc.ref_en, ifc.arb_state);
    end
    step();
    n_tests++;
    if (pins_obs() !== m_pins) begin
      n_fail++;
      $display("FAIL ref_pins_nop got %h want %h", pins_obs(), m_pins);
    end
  endtask

  task automatic test_priority();
    int exp_q[$];
    int got_q[$];
    ifc.ref_req = 1'b1;
    ifc.wr_req  = 1'b1;
    ifc.rd_req  = 1'b1;
    step(); got_q.push_back(int'(ifc.arb_state));
    ifc.ref_req = 1'b0; ifc.ref_end = 1'b1;
    step(); got_q.push_back(int'(ifc.arb_state));
    ifc.ref_end = 1'b0;
    step(); got_q.push_back(int'(ifc.arb_state));
    ifc.wr_req = 1'b0; ifc.wr_end = 1'b1;
    step(); got_q.push_back(int'(ifc.arb_state));
    ifc.wr_end = 1'b0;
    step(); got_q.push_back(int'(ifc.arb_state));
    ifc.rd_req = 1'b0; ifc.rd_end = 1'b1;
    step(); got_q.push_back(int'(ifc.arb_state));
    ifc.rd_end = 1'b0;
    exp_q = '{2, 1, 3, 1, 4, 1};
    foreach (exp_q[i]) begin
      n_tests++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL priority[%0d] got %0d want %0d",
                 i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_no_preempt();
    ifc.wr_req = 1'b1;
    step();
    ifc.wr_req  = 1'b0;
    ifc.ref_req = 1'b1;
    ifc.rd_end  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      ifc.rd_end = 1'b0;
      n_tests++;
      if (ifc.wr_en !== 1'b1 || ifc.ref_en !== 1'b0) begin
        n_fail++;
        $display("FAIL no_preempt[%0d] got wr=%b ref=%b want 1/0",
                 i, ifc.wr_en, ifc.ref_en);
      end
    end
    ifc.wr_end = 1'b1;
    step();
    ifc.wr_end = 1'b0;
    n_tests++;
    if (ifc.arb_state !== 3'd1 || ifc.wr_en !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_release got st=%0d wr=%b want 1/0",
               ifc.arb_state, ifc.wr_en);
    end
    step();
    n_tests++;
    if (ifc.arb_state !== 3'd2 || ifc.ref_en !== 1'b1) begin
      n_fail++;
      $display("FAIL ref_after_wr got st=%0d ref=%b want 2/1",
               ifc.arb_state, ifc.ref_en);
    end
    ifc.ref_req = 1'b0;
    ifc.ref_end = 1'b1;
    step();
    ifc.ref_end = 1'b0;
  endtask

  task automatic test_timeout();
    ifc.rd_req = 1'b1;
    step();
    ifc.rd_req = 1'b0;
    for (int i = 1; i < TO; i++) begin
      step();
      n_tests++;
      if (ifc.arb_state !== 3'd4 || ifc.err_timeout !== 1'b0) begin
        n_fail++;
        $display("FAIL timeout_hold[%0d] got st=%0d err=%b want 4/0",
                 i, ifc.arb_state, ifc.err_timeout);
      end
    end
    step();
    n_tests++;
    if (ifc.arb_state !== 3'd1 || ifc.err_timeout !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_fire got st=%0d err=%b want 1/1",
               ifc.arb_state, ifc.err_timeout);
    end
    repeat (3) step();
    n_tests++;
    if (ifc.err_timeout !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_sticky got %b want 1", ifc.err_timeout);
    end
  endtask

  task automatic test_reset_mid();
    ifc.rd_req = 1'b1;
    step();
    ifc.rd_req = 1'b0;
    ifc.rd_cmd = 18'h2a5a5;
    step();
    n_tests++;
    if (pins_obs() !== 18'h2a5a5) begin
      n_fail++;
      $display("FAIL rd_pins got %h want 2a5a5", pins_obs());
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_tests++;
    if (ifc.arb_state !== 3'd0 || ifc.rd_en !== 1'b0 ||
        pins_obs() !== NOP || ifc.err_timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid got st=%0d rd=%b pins=%h err=%b",
               ifc.arb_state, ifc.rd_en, pins_obs(), ifc.err_timeout);
    end
    set_idle();
  endtask

  task automatic test_random();
    for (int c = 0; c < 800; c++) begin
      rst          = ($urandom_range(0, 149) == 0);
      ifc.init_cmd = 18'($urandom);
      ifc.ref_cmd  = 18'($urandom);
      ifc.wr_cmd   = 18'($urandom);
      ifc.rd_cmd   = 18'($urandom);
      ifc.init_end = ($urandom_range(0, 3) == 0);
      ifc.ref_req  = ($urandom_range(0, 3) == 0);
      ifc.wr_req   = ($urandom_range(0, 1) == 0);
      ifc.rd_req   = ($urandom_range(0, 1) == 0);
      ifc.ref_end  = ($urandom_range(0, 9) == 0);
      ifc.wr_end   = ($urandom_range(0, 9) == 0);
      ifc.rd_end   = ($urandom_range(0, 12) == 0);
      step();
      n_tests++;
      if (ifc.arb_state !== 3'(m_st)) begin
        n_fail++;
        $display("FAIL rnd_state c=%0d got %0d want %0d",
                 c, ifc.arb_state, m_st);
      end
      n_tests++;
      if ({ifc.ref_en, ifc.wr_en, ifc.rd_en} !==
          {m_st == 2, m_st == 3, m_st == 4}) begin
        n_fail++;
        $display("FAIL rnd_grant c=%0d got %b want st %0d",
                 c, {ifc.ref_en, ifc.wr_en, ifc.rd_en}, m_st);
      end
      n_tests++;
      if (pins_obs() !== m_pins) begin
        n_fail++;
        $display("FAIL rnd_pins c=%0d got %h want %h",
                 c, pins_obs(), m_pins);
      end
      n_tests++;
      if (ifc.err_timeout !== m_err) begin
        n_fail++;
        $display("FAIL rnd_err c=%0d got %b want %b",
                 c, ifc.err_timeout, m_err);
      end
    end
    rst = 1'b0;
    set_idle();
  endtask

  initial begin
    set_idle();
    test_reset();
    test_init();
    test_ref();
    test_priority();
    test_no_preempt();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
